// File: rtl/led_fb_arbiter.sv
// Frame-buffer write arbiter with double-buffer swap control for the LED panel.
// Two writers share one pixel-memory write port; front/back flips only on v_sync.
`timescale 1ns/1ps
module led_fb_arbiter #(
  parameter int DISPLAY_ROWS_LINES = 4,
  parameter int DISPLAY_COLS_LINES = 6,
  localparam int AW = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [23:0]   data0,
  output logic          ack0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [23:0]   data1,
  output logic          ack1,
  input  logic          pat_en,
  input  logic          swap_req,
  input  logic          v_sync,
  output logic [AW-1:0] mem_addr,
  output logic [23:0]   mem_data,
  output logic          mem_buf,
  output logic          mem_write,
  output logic          fb_front,
  output logic          swap_pending,
  output logic          swap_done,
  output logic [7:0]    frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          rr_r, vs_q_r;
  logic          elig1_s, grant0_s, grant1_s, vs_rise_s;
  logic          fb_front_r, swap_pending_r, swap_done_r;
  logic          front_nxt_s, pending_nxt_s, done_nxt_s;
  logic [7:0]    frame_cnt_r;
  logic [AW-1:0] mem_addr_r;
  logic [23:0]   mem_data_r;
  logic          mem_buf_r, mem_write_r;

  // Round-robin grant: on contention the port other than the last winner wins.
  always_comb begin
    elig1_s  = req1 & pat_en;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0 && elig1_s) begin
      grant0_s = rr_r;
      grant1_s = ~rr_r;
    end else begin
      grant0_s = req0;
      grant1_s = elig1_s;
    end
  end

  assign ack0      = grant0_s;
  assign ack1      = grant1_s;
  assign vs_rise_s = v_sync & ~vs_q_r;

  // Write-port register, round-robin pointer, v_sync edge history and frame count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr_r  <= {AW{1'b0}};
      mem_data_r  <= 24'd0;
      mem_buf_r   <= 1'b0;
      mem_write_r <= 1'b0;
      rr_r        <= 1'b1;
      vs_q_r      <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      mem_write_r <= grant0_s | grant1_s;
      if (grant0_s) begin
        mem_addr_r <= addr0;
        mem_data_r <= data0;
        mem_buf_r  <= ~fb_front_r;
        rr_r       <= 1'b0;
      end else if (grant1_s) begin
        mem_addr_r <= addr1;
        mem_data_r <= data1;
        mem_buf_r  <= ~fb_front_r;
        rr_r       <= 1'b1;
      end else begin
        mem_addr_r <= mem_addr_r;
        mem_data_r <= mem_data_r;
        mem_buf_r  <= mem_buf_r;
        rr_r       <= rr_r;
      end
      vs_q_r      <= v_sync;
      frame_cnt_r <= frame_cnt_r + {7'd0, vs_rise_s};
    end
  end

  // Swap FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Swap FSM next state; a request arriving while armed or swapping is dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = swap_req  ? ST_ARMED : ST_IDLE;
      ST_ARMED: state_nxt_s = vs_rise_s ? ST_SWAP  : ST_ARMED;
      ST_SWAP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Swap FSM outputs, computed one edge ahead so the ports come straight off flops.
  always_comb begin
    front_nxt_s   = fb_front_r;
    pending_nxt_s = swap_pending_r;
    done_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE:  pending_nxt_s = swap_req ? 1'b1 : swap_pending_r;
      ST_ARMED: pending_nxt_s = 1'b1;
      ST_SWAP: begin
        front_nxt_s   = ~fb_front_r;
        pending_nxt_s = 1'b0;
        done_nxt_s    = 1'b1;
      end
      default: begin
        front_nxt_s   = fb_front_r;
        pending_nxt_s = 1'b0;
        done_nxt_s    = 1'b0;
      end
    endcase
  end

  // Registered swap status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fb_front_r     <= 1'b0;
      swap_pending_r <= 1'b0;
      swap_done_r    <= 1'b0;
    end else begin
      fb_front_r     <= front_nxt_s;
      swap_pending_r <= pending_nxt_s;
      swap_done_r    <= done_nxt_s;
    end
  end

  assign mem_addr     = mem_addr_r;
  assign mem_data     = mem_data_r;
  assign mem_buf      = mem_buf_r;
  assign mem_write    = mem_write_r;
  assign fb_front     = fb_front_r;
  assign swap_pending = swap_pending_r;
  assign swap_done    = swap_done_r;
  assign frame_cnt    = frame_cnt_r;

endmodule

// File: doc/led_fb_arbiter.md
# led_fb_arbiter

Frame-buffer write arbiter and double-buffer swap controller for the LED panel datapath. Two writers share the single pixel-memory write port that feeds the panel server: host port 0 and pattern-generator port 1. The block tags each write with the current back-buffer index and flips front/back buffers only on a frame boundary, signalled by the server's `v_sync` pulse. It runs entirely in the 200 MHz `CLK` domain.

## Interface
- `DISPLAY_ROWS_LINES`, default 4, row address bits per panel half.
- `DISPLAY_COLS_LINES`, default 6, column address bits.
- `AW` (local, not overridable), equal to `DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES+1`, pixel address width; MSB selects the lower half.

Ports:
- `CLK`  in  1  200 MHz system clock.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `req0`  in  1  port 0 (host) write request; held until acked.
- `addr0`  in  AW  port 0 pixel address.
- `data0`  in  24  port 0 RGB data.
- `ack0`  out  1  port 0 write accepted this cycle (combinational).
- `req1` / `addr1` / `data1` / `ack1`: port 1 (pattern generator), same widths and meaning.
- `pat_en`  in  1  enables port 1; when low, `req1` is ignored and `ack1` stays 0.
- `swap_req`  in  1  single-cycle pulse requesting a buffer swap.
- `v_sync`  in  1  frame-end pulse from the panel server; a rising edge is one frame boundary.
- `mem_addr`  out  AW  registered write address.
- `mem_data`  out  24  registered write data.
- `mem_buf`  out  1  buffer index for this write (back buffer).
- `mem_write`  out  1  registered write strobe.
- `fb_front`  out  1  buffer currently displayed.
- `swap_pending`  out  1  a swap is armed and waiting for a frame boundary.
- `swap_done`  out  1  one-cycle pulse when the swap takes effect.
- `frame_cnt`  out  8  count of frame boundaries; wraps.

## Operation
- Arbitration:
  - Round-robin between eligible requests. A port is eligible when its `req` is high; port 1 additionally needs `pat_en` high.
  - Pointer `rr` holds the last granted port; reset value is 1, so port 0 wins first.
  - One request eligible: it is granted.
  - Both eligible: the port not equal to `rr` is granted, then `rr` takes the granted index.
  - At most one `ack` is high per cycle. A request with no grant holds its `req`, `addr` and `data`.
- Write path:
  - On a grant, the next edge registers the granted address into `mem_addr` and its data into `mem_data`.
  - On the same edge, `mem_buf` is loaded with `~fb_front` as sampled in the grant cycle, and `mem_write` goes to 1.
  - With no grant, `mem_write` is 0 and `mem_addr`, `mem_data` and `mem_buf` hold their values.
- Frame boundary detection:
  - `v_sync` is registered into `vs_q`. The detect signal `vs_rise` is `v_sync & ~vs_q`, so a multi-cycle `v_sync` pulse counts once.
  - Every `vs_rise` increments `frame_cnt`, wrapping 255 to 0.
- Swap FSM:
  - IDLE: `swap_req` moves the FSM to ARMED and sets `swap_pending` to 1.
  - ARMED: `vs_rise` moves the FSM to SWAP; further `swap_req` pulses are ignored (no queuing).
  - SWAP, one cycle: toggle `fb_front`, pulse `swap_done`, clear `swap_pending`, return to IDLE.
- Simultaneous events:
  - `swap_req` in the same cycle as `vs_rise` while in IDLE: the FSM arms, and the swap waits for the next boundary.
  - A grant in the SWAP cycle still uses the pre-toggle back index.
  - A `swap_req` in the SWAP cycle is ignored.

## Timing
- Reset (async assert, sync release): `mem_write`, `mem_addr`, `mem_data`, `mem_buf` = 0. `fb_front` = 0, `swap_pending` = 0, `swap_done` = 0, `frame_cnt` = 0. FSM in IDLE, `rr` = 1, `vs_q` = 0.
- Reset mid-swap abandons the swap; `fb_front` returns to 0.
- Write latency: `ack` at edge N gives `mem_write` high during cycle N+1. Throughput is one write per cycle.
- Swap latency: `v_sync` rising at edge N gives `vs_rise` in cycle N, SWAP state after edge N+1, and `fb_front` toggled plus `swap_done` high after edge N+2.

## Test plan
- Reset and single write:
  - Stimulus: `RST_N` low then high; `req0`=1, `addr0`=0x155, `data0`=0xA5B6C7.
  - Required: `ack0` the same cycle; next cycle `mem_write`=1, `mem_addr`=0x155, `mem_data`=0xA5B6C7, `mem_buf`=1.
- Contention:
  - Stimulus: `req0`=`req1`=1 held for 4 cycles, `pat_en`=1.
  - Required: grants alternate 0,1,0,1, and `ack0`/`ack1` are never high together.
- Port 1 gating:
  - Stimulus: `pat_en`=0 with `req1`=1.
  - Required: `ack1` stays 0 and `mem_write` stays 0.
- Basic swap:
  - Stimulus: `swap_req` pulse, then a 4-cycle `v_sync` pulse 10 cycles later.
  - Required: `swap_pending`=1 until the swap; `swap_done` is one cycle, 2 cycles after the `v_sync` rise; `fb_front`=1; `frame_cnt` += 1 exactly once.
- Boundary cases:
  - Stimulus: `swap_req` coincident with a `vs_rise`.
  - Required: no swap until the next `v_sync`.
  - Stimulus: second `swap_req` while ARMED.
  - Required: a single toggle.
  - Stimulus: 256 `v_sync` pulses.
  - Required: `frame_cnt` returns to 0.
- Async reset:
  - Stimulus: `RST_N` low between edges while ARMED with `fb_front`=1.
  - Required: all outputs go to reset values immediately, without waiting for a `CLK` edge.
